mr_scoreboard: RTL and testbench
================================

# mr_scoreboard

Issue controller that sits between decode and `mr_alu` and decides, every cycle, whether the decoded instruction may enter the ALU. It tracks in-flight register writes with a per-register pending counter and stalls read-after-write and write-after-write hazards until writeback retires the producer. It also sequences the pipeline flush after a taken branch and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- `NREGS`, default 32: architectural register count; x0 is never tracked.
- `REGSEL_BITS`, default 5: register index width, equal to `$clog2(NREGS)`.
- `CNT_BITS`, default 2: pending-counter width; up to `2**CNT_BITS-1` writes in flight per register.
- `FLUSH_DEPTH`, default 2: number of cycles `flush` is held after a taken branch.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dec_valid`  in  1  decode presents an instruction.
- `dec_rs1`, `dec_rs2`  in  REGSEL_BITS  source registers.
- `dec_rs1_used`, `dec_rs2_used`  in  1  source is actually read.
- `dec_rd`  in  REGSEL_BITS  destination register; 0 means no write.
- `alu_ready`  in  1  ALU can accept an instruction this cycle (its `id_ready`).
- `dec_stall`  out  1  combinational; decode must hold its instruction.
- `issue`  out  1  combinational; the instruction is accepted this cycle.
- `wb_valid`  in  1  one instruction leaves writeback, including squashed instructions.
- `wb_reg`  in  REGSEL_BITS  destination of the leaving instruction; 0 means none.
- `br_taken`  in  1  taken branch reported by the ALU (its `wb_pc_valid`).
- `flush`  out  1  registered; kills younger instructions in decode and ALU input.
- `idle`  out  1  combinational; all pending counters are zero and the state is RUN.
- `stall_cycles`  out  32  registered; saturating count of cycles with `dec_valid && dec_stall`.

## Operation
- Hazard: `haz = (rs1_used && rs1!=0 && pend[rs1]!=0) || (rs2_used && rs2!=0 && pend[rs2]!=0) || (rd!=0 && pend[rd]!=0)`.
- Saturation guard: if `rd!=0` and `pend[rd]` is at its maximum value, treat it as a hazard. This is covered by the WAW term above but must also hold if WAW checking is relaxed later.
- `dec_stall = dec_valid && (haz || state!=RUN || !alu_ready)`.
- `issue = dec_valid && !dec_stall`.
- Counters:
  - issue with `rd!=0`: `pend[rd]+1`.
  - `wb_valid` with `wb_reg!=0`: `pend[wb_reg]-1`.
  - Both in the same cycle on the same register: no change.
  - A decrement at zero is a protocol error: the counter stays 0 and the error is flagged by a simulation-only assertion.
- There is no bypass. A retire in cycle N clears the hazard from cycle N+1.
- Flush FSM with states RUN and FLUSH, and a down-counter `fcnt` of width `$clog2(FLUSH_DEPTH+1)`:
  - RUN, `br_taken` → FLUSH with `fcnt=FLUSH_DEPTH-1`, `flush<=1`.
  - FLUSH, `fcnt!=0` → `fcnt-1`, `flush` stays 1.
  - FLUSH, `fcnt==0` → RUN, `flush<=0`.
  - `br_taken` while in FLUSH comes from a squashed instruction and is ignored.
- Squashed instructions still reach writeback and assert `wb_valid`. The scoreboard is therefore never cleared by a flush.
- `stall_cycles` increments when `dec_valid && dec_stall` and holds at `32'hFFFF_FFFF`.

## Timing
- Reset values (asynchronous on `rst_n` low): all `pend`=0, state RUN, `fcnt`=0, `flush`=0, `stall_cycles`=0. Consequently `idle`=1, `dec_stall`=0, and `issue` follows `dec_valid && alu_ready`.
- Reset asserted mid-operation discards all in-flight tracking immediately. The surrounding pipeline is reset by the same `rst_n`.
- `dec_stall`, `issue` and `idle` are combinational from the inputs and current state, with zero latency. Counter and FSM effects are visible the following cycle.
- `flush` rises one cycle after `br_taken` is sampled and stays high exactly `FLUSH_DEPTH` cycles. No issue happens while the state is FLUSH.
- Decode holds all `dec_*` inputs stable while `dec_stall`=1.

## Structure
- The shared package, alongside the existing ALU and branch enums, holds:
  - `e_sb_state` enum with values `SB_RUN` and `SB_FLUSH`.
  - a `SB_CNT_BITS` constant.
- One sub-module, `mr_sb_counter`: a single up/down pending counter with inc/dec inputs and zero/full flags. It is instantiated `NREGS-1` times with a generate loop, for indices 1 to NREGS-1.
- The FSM, hazard logic and stall counter live in the top module.

## Test plan
- RAW: issue `rd=5`, next cycle `dec_rs1=5` used → `dec_stall`=1. Drive `wb_valid`, `wb_reg=5` in cycle N → `issue`=1 in cycle N+1, and `stall_cycles` equals the stalled cycle count.
- Independent stream: `rd=1..4` with no shared sources, `alu_ready`=1 → `issue` every cycle. After 4 retires, `idle`=1.
- Simultaneous events: issue `rd=7` in the same cycle that `wb_reg=7` retires while `pend[7]=1` → `pend[7]` stays 1. Then `dec_rs2=7` stalls.
- Branch: `br_taken` at cycle 10 → `flush`=1 in cycles 11-12 with `FLUSH_DEPTH=2`, no issue in cycles 11-12. A second `br_taken` at cycle 11 is ignored. Squashed retires drain to `idle`.
- Saturation: three issues to `rd=3` with WAW checking disabled by force → the fourth is stalled. Set `stall_cycles` near `32'hFFFF_FFFE` → it saturates at `FFFF_FFFF`.
- Reset mid-operation: with `pend[9]=2` and state FLUSH, pulse `rst_n` low asynchronously between edges → outputs return to reset values immediately, and `rs1=9` issues on the first cycle after release.

Source files
------------

// File: rtl/mr_scoreboard_pkg.sv
// Shared types for the mr pipeline: ALU and branch enums plus the
// issue-scoreboard state encoding and sizing constants.
package mr_scoreboard_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } e_alu_op;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2,
        BR_JMP  = 2'd3
    } e_br_kind;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_FLUSH = 1'b1
    } e_sb_state;

    // Pending-counter width: up to 2**SB_CNT_BITS-1 writes in flight per register.
    localparam int SB_CNT_BITS    = 2;
    localparam int SB_FLUSH_DEPTH = 2;

endpackage

// File: rtl/mr_scoreboard_if.sv
// Decode / ALU / writeback handshake bundle seen by the issue scoreboard.
interface mr_scoreboard_if #(
    parameter int REGSEL_BITS = 5
);
    logic                   dec_valid;
    logic [REGSEL_BITS-1:0] dec_rs1;
    logic [REGSEL_BITS-1:0] dec_rs2;
    logic                   dec_rs1_used;
    logic                   dec_rs2_used;
    logic [REGSEL_BITS-1:0] dec_rd;
    logic                   alu_ready;
    logic                   dec_stall;
    logic                   issue;
    logic                   wb_valid;
    logic [REGSEL_BITS-1:0] wb_reg;
    logic                   br_taken;
    logic                   flush;
    logic                   idle;
    logic [31:0]            stall_cycles;

    // Pipeline side: drives decode, ALU readiness and writeback.
    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd,
        output alu_ready, wb_valid, wb_reg, br_taken,
        input  dec_stall, issue, flush, idle, stall_cycles
    );

    // Scoreboard side.
    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd,
        input  alu_ready, wb_valid, wb_reg, br_taken,
        output dec_stall, issue, flush, idle, stall_cycles
    );
endinterface

// File: rtl/mr_sb_counter.sv
// One per-register pending-write counter. Increments on issue, decrements on
// retire; a simultaneous inc/dec cancels. Never wraps in either direction.
module mr_sb_counter #(
    parameter int W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic full
);
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] cnt_r;

    // Up/down update with saturation at both ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (inc && !dec && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else if (dec && !inc && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == '0);
    assign full = (cnt_r == CNT_MAX);

    mr_sb_counter_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc),
        .dec   (dec),
        .zero  (zero)
    );
endmodule

// Protocol checker: a retire must never hit a register with nothing pending.
module mr_sb_counter_chk (
    input logic clk,
    input logic rst_n,
    input logic inc,
    input logic dec,
    input logic zero
);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec && !inc && zero));
endmodule

// File: rtl/mr_scoreboard.sv
// Issue scoreboard between decode and mr_alu: RAW/WAW hazard stall, post-branch
// flush sequencing and a saturating stall-cycle performance counter.
module mr_scoreboard
    import mr_scoreboard_pkg::*;
#(
    parameter int NREGS       = 32,
    parameter int REGSEL_BITS = 5,
    parameter int CNT_BITS    = SB_CNT_BITS,
    parameter int FLUSH_DEPTH = SB_FLUSH_DEPTH
) (
    input logic            clk,
    input logic            rst_n,
    mr_scoreboard_if.slave sb
);
    localparam int FCW = $clog2(FLUSH_DEPTH + 1);

    logic [NREGS-1:0] zero_s;
    logic [NREGS-1:0] full_s;
    logic             waw_en_s;
    logic             haz_s;
    logic             dec_stall_s;
    logic             issue_s;
    logic             idle_s;
    logic             flush_nxt_s;
    e_sb_state        state_r;
    e_sb_state        state_nxt_s;
    logic [FCW-1:0]   fcnt_r;
    logic [FCW-1:0]   fcnt_nxt_s;
    logic             flush_r;
    logic [31:0]      stall_cycles_r;

    // WAW checking switch; the saturation guard below stands on its own.
    assign waw_en_s = 1'b1;

    // x0 is never tracked: it always reads as "nothing pending".
    assign zero_s[0] = 1'b1;
    assign full_s[0] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_pend
        logic inc_s;
        logic dec_s;
        assign inc_s = issue_s && (sb.dec_rd == REGSEL_BITS'(i));
        assign dec_s = sb.wb_valid && (sb.wb_reg == REGSEL_BITS'(i));
        mr_sb_counter #(.W(CNT_BITS)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_s),
            .dec   (dec_s),
            .zero  (zero_s[i]),
            .full  (full_s[i])
        );
    end

    // Hazard detection: RAW on either source, WAW on rd, and rd counter full.
    always_comb begin
        haz_s = 1'b0;
        if (sb.dec_rs1_used && (sb.dec_rs1 != '0) && !zero_s[sb.dec_rs1]) begin
            haz_s = 1'b1;
        end else if (sb.dec_rs2_used && (sb.dec_rs2 != '0) && !zero_s[sb.dec_rs2]) begin
            haz_s = 1'b1;
        end else if (waw_en_s && (sb.dec_rd != '0) && !zero_s[sb.dec_rd]) begin
            haz_s = 1'b1;
        end else if ((sb.dec_rd != '0) && full_s[sb.dec_rd]) begin
            haz_s = 1'b1;
        end else begin
            haz_s = 1'b0;
        end
    end

    // Flush FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SB_RUN;
            fcnt_r  <= '0;
            flush_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
            flush_r <= flush_nxt_s;
        end
    end

    // Flush FSM next state; a branch seen while flushing is from a squashed op.
    always_comb begin
        state_nxt_s = state_r;
        fcnt_nxt_s  = fcnt_r;
        case (state_r)
            SB_RUN: begin
                if (sb.br_taken) begin
                    state_nxt_s = SB_FLUSH;
                    fcnt_nxt_s  = FCW'(FLUSH_DEPTH - 1);
                end else begin
                    state_nxt_s = SB_RUN;
                end
            end
            SB_FLUSH: begin
                if (fcnt_r != '0) begin
                    fcnt_nxt_s = fcnt_r - FCW'(1);
                end else begin
                    state_nxt_s = SB_RUN;
                end
            end
            default: begin
                state_nxt_s = SB_RUN;
                fcnt_nxt_s  = '0;
            end
        endcase
    end

    // Outputs: zero-latency issue/stall/idle and the next registered flush.
    always_comb begin
        flush_nxt_s = (state_nxt_s == SB_FLUSH);
        dec_stall_s = sb.dec_valid && (haz_s || (state_r != SB_RUN) || !sb.alu_ready);
        issue_s     = sb.dec_valid && !dec_stall_s;
        idle_s      = (&zero_s) && (state_r == SB_RUN);
    end

    // Saturating count of cycles in which decode is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= 32'd0;
        end else if (sb.dec_valid && dec_stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign sb.dec_stall    = dec_stall_s;
    assign sb.issue        = issue_s;
    assign sb.idle         = idle_s;
    assign sb.flush        = flush_r;
    assign sb.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_mr_scoreboard.sv
// Directed bench for mr_scoreboard: stimulus pushes the expected per-cycle
// outputs into a queue, and a monitor pops and compares mid-cycle.
module tb_mr_scoreboard;

    typedef struct packed {
        logic        issue;
        logic        stall;
        logic        flush;
        logic        idle;
        logic [31:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mr_scoreboard_if #(.REGSEL_BITS(5)) sb_if ();

    mr_scoreboard #(
        .NREGS       (32),
        .REGSEL_BITS (5),
        .CNT_BITS    (2),
        .FLUSH_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    // Drive one cycle of inputs just after the falling edge.
    task automatic dr(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic ar, input logic wbv, input logic [4:0] wbr,
                      input logic br);
        @(negedge clk);
        sb_if.dec_valid    = v;
        sb_if.dec_rs1      = rs1;
        sb_if.dec_rs1_used = u1;
        sb_if.dec_rs2      = rs2;
        sb_if.dec_rs2_used = u2;
        sb_if.dec_rd       = rd;
        sb_if.alu_ready    = ar;
        sb_if.wb_valid     = wbv;
        sb_if.wb_reg       = wbr;
        sb_if.br_taken     = br;
    endtask

    task automatic idle_cyc();
        dr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic retire(input logic [4:0] r);
        dr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, r, 1'b0);
    endtask

    // Expected outputs for the cycle just driven.
    task automatic ex(input logic i, input logic s, input logic f, input logic id,
                      input logic [31:0] sc);
        exp_t e;
        e.issue = i;
        e.stall = s;
        e.flush = f;
        e.idle  = id;
        e.sc    = sc;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare every pending expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue", {31'd0, sb_if.issue}, {31'd0, e.issue});
                chk("dec_stall", {31'd0, sb_if.dec_stall}, {31'd0, e.stall});
                chk("flush", {31'd0, sb_if.flush}, {31'd0, e.flush});
                chk("idle", {31'd0, sb_if.idle}, {31'd0, e.idle});
                chk("stall_cycles", sb_if.stall_cycles, e.sc);
            end
        end
    end

    initial begin
        rst_n              = 1'b0;
        sb_if.dec_valid    = 1'b0;
        sb_if.dec_rs1      = 5'd0;
        sb_if.dec_rs1_used = 1'b0;
        sb_if.dec_rs2      = 5'd0;
        sb_if.dec_rs2_used = 1'b0;
        sb_if.dec_rd       = 5'd0;
        sb_if.alu_ready    = 1'b0;
        sb_if.wb_valid     = 1'b0;
        sb_if.wb_reg       = 5'd0;
        sb_if.br_taken     = 1'b0;

        // Reset state: issue follows dec_valid && alu_ready.
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        ex(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        #3 rst_n = 1'b1;

        // RAW on r5, retire in cycle N, issue in N+1.
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0); ex(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        dr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0); ex(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        dr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0); ex(1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
        dr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0); ex(1'b0, 1'b1, 1'b0, 1'b0, 32'd2);
        dr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0); ex(1'b1, 1'b0, 1'b0, 1'b1, 32'd3);
        idle_cyc(); ex(1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
        // ALU not ready stalls without any hazard.
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0); ex(1'b0, 1'b1, 1'b0, 1'b1, 32'd3);

        // Independent stream r1..r4, then four retires drain to idle.
        for (int k = 1; k <= 4; k++) begin
            dr(1'b1, 5'(k + 10), 1'b1, 5'(k + 20), 1'b1, 5'(k), 1'b1, 1'b0, 5'd0, 1'b0);
            ex(1'b1, 1'b0, 1'b0, (k == 1), 32'd4);
        end
        for (int k = 1; k <= 4; k++) begin
            retire(5'(k)); ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd4);
        end
        idle_cyc(); ex(1'b0, 1'b0, 1'b0, 1'b1, 32'd4);

        // Simultaneous issue and retire on r7 leaves one pending (WAW relaxed).
        force dut.waw_en_s = 1'b0;
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0); ex(1'b1, 1'b0, 1'b0, 1'b1, 32'd4);
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0); ex(1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
        dr(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0); ex(1'b0, 1'b1, 1'b0, 1'b0, 32'd4);
        retire(5'd7); ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd5);
        idle_cyc(); ex(1'b0, 1'b0, 1'b0, 1'b1, 32'd5);

        // Saturation guard: three writes to r3 in flight, the fourth stalls.
        for (int k = 0; k < 3; k++) begin
            dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
            ex(1'b1, 1'b0, 1'b0, (k == 0), 32'd5);
        end
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0); ex(1'b0, 1'b1, 1'b0, 1'b0, 32'd5);
        for (int k = 0; k < 3; k++) begin
            retire(5'd3); ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd6);
        end
        idle_cyc(); ex(1'b0, 1'b0, 1'b0, 1'b1, 32'd6);
        release dut.waw_en_s;

        // WAW stall with normal checking.
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0); ex(1'b1, 1'b0, 1'b0, 1'b1, 32'd6);
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0); ex(1'b0, 1'b1, 1'b0, 1'b0, 32'd6);
        retire(5'd8); ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd7);
        idle_cyc(); ex(1'b0, 1'b0, 1'b0, 1'b1, 32'd7);

        // Branch: flush two cycles, second br_taken ignored, squashed retire drains.
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 5'd0, 1'b1); ex(1'b1, 1'b0, 1'b0, 1'b1, 32'd7);
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1);  ex(1'b0, 1'b1, 1'b1, 1'b0, 32'd7);
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);  ex(1'b0, 1'b1, 1'b1, 1'b0, 32'd8);
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);  ex(1'b1, 1'b0, 1'b0, 1'b0, 32'd9);
        retire(5'd10); ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd9);
        idle_cyc(); ex(1'b0, 1'b0, 1'b0, 1'b1, 32'd9);

        // Stall counter saturation from just below all-ones.
        @(negedge clk);
        force dut.stall_cycles_r = 32'hFFFF_FFFE;
        #1 release dut.stall_cycles_r;
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); ex(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); ex(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        idle_cyc(); ex(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);

        // Mid-operation reset with pend[9]=2 and state FLUSH.
        force dut.waw_en_s = 1'b0;
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0); ex(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        dr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b1); ex(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        idle_cyc();
        release dut.waw_en_s;
        ex(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        dr(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0); ex(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        idle_cyc(); ex(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);

        @(negedge clk);
        #4;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
